encoder_scan: RTL and testbench
===============================

# encoder_scan

Parametrised, sequential successor to the 8-to-3 encoder. It accepts an N-bit request vector over a valid/ready handshake and emits the binary index of every set bit, one per output beat. Indices come out in priority order, lowest-first or highest-first, and the final beat is flagged. It sits between request-collection logic (interrupt or event vectors) and any consumer that services one index at a time.

## Interface
- `N`, default 8: input vector width; N ≥ 2.
- `LSB_FIRST`, default 1: 1 emits the lowest set index first, 0 emits the highest set index first.
- `W`, localparam, equal to $clog2(N): index width. It is not overridable.
- `clk`  in  1  sole clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `en`  in  1  global enable; low freezes the block.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  block can accept a vector.
- `in_data`  in  N  request vector.
- `out_valid`  out  1  `out_idx` is valid.
- `out_ready`  in  1  consumer takes the beat.
- `out_idx`  out  W  binary index of the current set bit.
- `out_last`  out  1  current beat is the final beat for this vector.
- `out_zero`  out  1  the accepted vector was all-zero.
- `busy`  out  1  state is SCAN.

## Operation
- Registers:
  - `state`: one of IDLE or SCAN.
  - `pend[N-1:0]`: remaining bits.
  - `zflag`: set when the captured vector was zero.
- IDLE:
  - `in_ready` = en & rst_n.
  - Accept when `in_valid & in_ready`: `pend` <= `in_data`, `zflag` <= (`in_data`==0), state <= SCAN.
- SCAN:
  - `out_valid` = en.
  - `out_idx` = priority index of `pend`; 0 if `pend`==0.
  - `out_last` = `pend` has at most one bit set.
  - `out_zero` = `zflag`.
  - On `out_valid & out_ready`: clear bit `out_idx` in `pend`. If `out_last`, state <= IDLE and `zflag` <= 0.
- All-zero vector: produces exactly one beat with `out_idx`=0, `out_last`=1, `out_zero`=1.
- Non-zero vector with k set bits: produces exactly k beats, `out_zero`=0 on all of them.
- `in_ready`=0 throughout SCAN. No new vector is accepted until the last beat is consumed.
- `en`=0:
  - `in_ready`=0 and `out_valid`=0.
  - All registers hold. No handshake completes in either direction.
  - Scanning resumes unchanged when `en` returns.
- Outputs are pure decodes of registers plus `en`/`rst_n`. There is no combinational path from `in_data`, `in_valid` or `out_ready` to any output.

## Timing
- Reset: on any edge with `rst_n`=0, state <= IDLE, `pend` <= 0, `zflag` <= 0. While `rst_n`=0, `in_ready`=0 and `out_valid`=0.
- After reset, the outputs are `in_ready`=en, `out_valid`=0, `out_idx`=0, `out_last`=0, `out_zero`=0, `busy`=0.
- Reset asserted mid-scan discards the vector. No further beats are produced, even if `out_ready` is high in that cycle.
- Latency: a vector accepted at edge t gives its first `out_valid` in the cycle after t.
- Throughput: one index per cycle while `out_ready`=1.
- Per-vector cycles: a vector with k set bits occupies 1 + max(k,1) cycles, including the one IDLE cycle before the next acceptance.
- Backpressure: while `out_valid`=1 and `out_ready`=0, `out_idx`, `out_last` and `out_zero` hold stable.
- Simultaneous events: there are none. Input and output handshakes never complete in the same cycle.

## Structure
- Shared package/include holds:
  - State encodings `ST_IDLE`=1'b0, `ST_SCAN`=1'b1.
  - A `CLOG2` helper, for tools without $clog2.
- Sub-module `prio_encoder_n`:
  - Combinational, parameters `N` and `LSB_FIRST`.
  - Input `vec[N-1:0]`.
  - Outputs `idx[W-1:0]`, `any`, `single`.
  - Instantiated once on `pend`.
- The top level contains only the FSM, the `pend`/`zflag` registers and handshake glue.

## Test plan
All scenarios use N=8 unless stated.

- **Reset:** `rst_n`=0 for 2 cycles with `in_valid`=1 and `in_data`=8'hFF -> `in_ready`=0 and `out_valid`=0 throughout. In the first cycle after release, `in_ready`=1 and no beat has been emitted.
- **LSB-first scan:** LSB_FIRST=1, `in_data`=8'b1001_0100 accepted at edge t, `out_ready`=1 -> `out_idx` 2, 4, 7 in cycles t+1..t+3. `out_last`=1 only on 7. `in_ready`=1 at t+4.
- **MSB-first scan:** LSB_FIRST=0, same vector -> `out_idx` 7, 4, 2, with `out_last` on 2.
- **Backpressure and enable:**
  - `out_ready`=0 for 3 cycles during the first beat -> `out_idx`=2 held stable, `pend` unchanged.
  - `en`=0 for 2 cycles mid-scan -> `out_valid`=0, then the scan resumes at the same index.
- **Zero vector and reset mid-scan:**
  - 8'h00 -> single beat with `out_idx`=0, `out_last`=1, `out_zero`=1.
  - 8'hFF then `rst_n`=0 after the 3rd beat -> IDLE on the next cycle, no further beats.
- **Non-power-of-two width:** N=5, `in_data`=5'b10001 -> W=3, `out_idx` 0 then 4, `out_last` on 4.

Source files
------------

// File: rtl/encoder_scan_pkg.sv
// Shared definitions for the sequential set-bit scanner: FSM state encodings
// and a ceil(log2) helper for tools that lack $clog2.
package encoder_scan_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    function automatic int CLOG2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/encoder_scan_prio.sv
// Combinational N-bit priority encoder: index of the lowest (or highest) set
// bit, plus flags for "any bit set" and "at most one bit set".
module prio_encoder_n
    import encoder_scan_pkg::*;
#(
    parameter int  N         = 8,
    parameter bit  LSB_FIRST = 1'b1,
    localparam int W         = CLOG2(N)
) (
    input  logic [N-1:0] vec,
    output logic [W-1:0] idx,
    output logic         any,
    output logic         single
);

    logic w_found;

    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        idx     = '0;
        w_found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!w_found && vec[LSB_FIRST ? i : N - 1 - i]) begin
                idx     = W'(LSB_FIRST ? i : N - 1 - i);
                w_found = 1'b1;
            end
        end
    end

    assign any    = |vec;
    // Clearing the lowest set bit leaves zero exactly when popcount <= 1.
    assign single = ((vec & (vec - N'(1))) == '0);

endmodule

// File: rtl/encoder_scan.sv
// Accepts an N-bit request vector and replays the index of each set bit, one
// per output beat, in priority order; an all-zero vector yields one zero beat.
module encoder_scan
    import encoder_scan_pkg::*;
#(
    parameter int  N         = 8,
    parameter bit  LSB_FIRST = 1'b1,
    localparam int W         = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_idx,
    output logic         out_last,
    output logic         out_zero,
    output logic         busy
);

    state_t       r_state;
    logic [N-1:0] r_pend;
    logic         r_zflag;

    state_t       w_state_nxt;
    logic [N-1:0] w_pend_nxt;
    logic         w_zflag_nxt;

    logic [W-1:0] w_idx;
    logic         w_any;
    logic         w_single;
    logic         w_scan;
    logic         w_in_fire;
    logic         w_out_fire;

    prio_encoder_n #(
        .N         (N),
        .LSB_FIRST (LSB_FIRST)
    ) u_prio (
        .vec    (r_pend),
        .idx    (w_idx),
        .any    (w_any),
        .single (w_single)
    );

    // Outputs decode registers plus en/rst_n only; in_data, in_valid and
    // out_ready never reach an output combinationally.
    assign w_scan    = (r_state == ST_SCAN);
    assign in_ready  = en & rst_n & ~w_scan;
    assign out_valid = en & rst_n & w_scan;
    assign out_idx   = (w_scan && w_any) ? w_idx : '0;
    assign out_last  = w_scan & w_single;
    assign out_zero  = r_zflag;
    assign busy      = w_scan;

    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = out_valid & out_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_pend_nxt  = r_pend;
        w_zflag_nxt = r_zflag;
        case (r_state)
            ST_IDLE: begin
                if (w_in_fire) begin
                    w_pend_nxt  = in_data;
                    w_zflag_nxt = (in_data == '0);
                    w_state_nxt = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (w_out_fire) begin
                    w_pend_nxt = r_pend & ~(N'(1) << out_idx);
                    if (w_single) begin
                        w_state_nxt = ST_IDLE;
                        w_zflag_nxt = 1'b0;
                    end
                end
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_pend  <= '0;
            r_zflag <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pend  <= w_pend_nxt;
            r_zflag <= w_zflag_nxt;
        end
    end

endmodule

// File: tb/tb_encoder_scan.sv
// Directed bench for encoder_scan: LSB-first N=8, MSB-first N=8 and LSB-first
// N=5 instances run side by side against a transaction-level model.
module tb_encoder_scan;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, en, in_valid, out_ready;
    logic [7:0] in_data;
    logic [4:0] in_data5;
    logic [2:0] rdy, vld, last, zero, bsy;
    logic [2:0] idx [3];

    encoder_scan #(.N(8), .LSB_FIRST(1'b1)) dut_lsb (
        .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_ready(rdy[0]),
        .in_data(in_data), .out_valid(vld[0]), .out_ready(out_ready), .out_idx(idx[0]),
        .out_last(last[0]), .out_zero(zero[0]), .busy(bsy[0]));

    encoder_scan #(.N(8), .LSB_FIRST(1'b0)) dut_msb (
        .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_ready(rdy[1]),
        .in_data(in_data), .out_valid(vld[1]), .out_ready(out_ready), .out_idx(idx[1]),
        .out_last(last[1]), .out_zero(zero[1]), .busy(bsy[1]));

    encoder_scan #(.N(5), .LSB_FIRST(1'b1)) dut_n5 (
        .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_ready(rdy[2]),
        .in_data(in_data5), .out_valid(vld[2]), .out_ready(out_ready), .out_idx(idx[2]),
        .out_last(last[2]), .out_zero(zero[2]), .busy(bsy[2]));

    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;

    // Model: on acceptance the set-bit indices are listed in emission order;
    // each consumed beat advances a pointer through that list.
    int m_seq [3][8];
    int m_pos [3];
    int m_cnt [3];
    bit m_scan[3];
    bit m_zf  [3];

    int obs0[$];
    int obs1[$];
    int obs2[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit e_rdy(input int d);
        return en && rst_n && !m_scan[d];
    endfunction

    function automatic bit e_vld(input int d);
        return en && rst_n && m_scan[d];
    endfunction

    // Beat count in bits 31:24, indices packed 4 bits each, first beat most significant.
    function automatic logic [31:0] qval(input int q[$]);
        logic [31:0] r;
        r = '0;
        foreach (q[i]) r = (r << 4) | 32'(q[i] & 15);
        return r | (32'(q.size()) << 24);
    endfunction

    always @(posedge clk) begin
        bit hs_in [3];
        bit hs_out[3];
        for (int d = 0; d < 3; d++) begin
            hs_in[d]  = e_rdy(d) && in_valid;
            hs_out[d] = e_vld(d) && out_ready;
        end
        for (int d = 0; d < 3; d++) begin
            if (!rst_n) begin
                m_scan[d] = 1'b0;
                m_zf[d]   = 1'b0;
                m_pos[d]  = 0;
                m_cnt[d]  = 0;
            end else if (hs_in[d]) begin
                automatic logic [7:0] v = (d == 2) ? {3'b000, in_data5} : in_data;
                automatic int n = (d == 2) ? 5 : 8;
                automatic int c = 0;
                for (int j = 0; j < n; j++) begin
                    automatic int b = (d == 1) ? n - 1 - j : j;
                    if (v[b]) begin
                        m_seq[d][c] = b;
                        c++;
                    end
                end
                m_zf[d] = (c == 0);
                if (c == 0) begin
                    m_seq[d][0] = 0;
                    c = 1;
                end
                m_cnt[d]  = c;
                m_pos[d]  = 0;
                m_scan[d] = 1'b1;
            end else if (hs_out[d]) begin
                m_pos[d]++;
                if (m_pos[d] == m_cnt[d]) begin
                    m_scan[d] = 1'b0;
                    m_zf[d]   = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            for (int d = 0; d < 3; d++) begin
                automatic int ei = m_scan[d] ? m_seq[d][m_pos[d]] : 0;
                check($sformatf("d%0d in_ready", d),  32'(rdy[d]),  32'(e_rdy(d)));
                check($sformatf("d%0d out_valid", d), 32'(vld[d]),  32'(e_vld(d)));
                check($sformatf("d%0d out_idx", d),   32'(idx[d]),  32'(ei));
                check($sformatf("d%0d out_last", d),  32'(last[d]), 32'(m_scan[d] && m_pos[d] == m_cnt[d] - 1));
                check($sformatf("d%0d out_zero", d),  32'(zero[d]), 32'(m_zf[d]));
                check($sformatf("d%0d busy", d),      32'(bsy[d]),  32'(m_scan[d]));
            end
            if (out_ready) begin
                if (vld[0]) obs0.push_back(int'(idx[0]));
                if (vld[1]) obs1.push_back(int'(idx[1]));
                if (vld[2]) obs2.push_back(int'(idx[2]));
            end
        end
    end

    task automatic clear_obs();
        obs0.delete();
        obs1.delete();
        obs2.delete();
    endtask

    // Raise in_valid for exactly one edge; returns 1 ns after the accepting edge.
    task automatic pulse_in();
        @(posedge clk); #1;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
        in_data = 8'hFF; in_data5 = 5'h1F;

        // Reset held over two edges with a valid vector offered.
        @(posedge clk); #1;
        chk_on = 1'b1;
        @(negedge clk);
        check("reset in_ready", 32'(rdy), 32'h0);
        check("reset out_valid", 32'(vld), 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        check("post-reset in_ready", 32'(rdy), 32'h7);
        check("post-reset beats", 32'(obs0.size() + obs1.size() + obs2.size()), 32'h0);

        // Free-running scan of 1001_0100 (and 10001 on the N=5 instance).
        clear_obs();
        out_ready = 1'b1; in_data = 8'b1001_0100; in_data5 = 5'b10001;
        pulse_in();
        @(negedge clk);
        check("lsb first beat", 32'(idx[0]), 32'd2);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("lsb in_ready t+4", 32'(rdy[0]), 32'd1);
        repeat (2) @(posedge clk); #1;
        check("lsb beats", qval(obs0), 32'h0300_0247);
        check("msb beats", qval(obs1), 32'h0300_0742);
        check("n5 beats",  qval(obs2), 32'h0200_0004);

        // Backpressure for 3 cycles, one beat, then en low for 2 cycles.
        clear_obs();
        out_ready = 1'b0;
        pulse_in();
        @(negedge clk);
        check("bp first idx", 32'(idx[0]), 32'd2);
        repeat (2) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("bp held idx", 32'(idx[0]), 32'd2);
        check("bp held valid", 32'(vld[0]), 32'd1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        en = 1'b0;
        @(negedge clk);
        check("en low valid", 32'(vld), 32'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        en = 1'b1;
        @(negedge clk);
        check("resume idx", 32'(idx[0]), 32'd4);
        check("resume valid", 32'(vld[0]), 32'd1);
        repeat (4) @(posedge clk); #1;
        check("bp lsb beats", qval(obs0), 32'h0300_0247);
        check("bp n5 beats",  qval(obs2), 32'h0200_0004);

        // All-zero vector: one beat flagged last and zero.
        clear_obs();
        in_data = 8'h00; in_data5 = 5'h00;
        pulse_in();
        @(negedge clk);
        check("zero idx", 32'(idx[0]), 32'd0);
        check("zero last", 32'(last[0]), 32'd1);
        check("zero flag", 32'(zero[0]), 32'd1);
        repeat (3) @(posedge clk); #1;
        check("zero beats", qval(obs0), 32'h0100_0000);
        check("zero idle", 32'(bsy), 32'h0);

        // Full vector, reset asserted after the third beat with out_ready high.
        clear_obs();
        in_data = 8'hFF; in_data5 = 5'h1F;
        pulse_in();
        repeat (3) @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        check("reset mid valid", 32'(vld), 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("after reset busy", 32'(bsy), 32'h0);
        check("after reset ready", 32'(rdy), 32'h7);
        repeat (3) @(posedge clk); #1;
        check("cut lsb beats", qval(obs0), 32'h0300_0012);
        check("cut msb beats", qval(obs1), 32'h0300_0765);
        check("cut n5 beats",  qval(obs2), 32'h0300_0012);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
